// File: rtl/seq_run_detector_pkg.sv
// Shared constants and helpers for the serial run detector.
package seq_run_detector_pkg;

    // FSM state codes; 2'b11 is unused and recovered to idle.
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN0 = 2'b01;
    localparam logic [1:0] ST_RUN1 = 2'b10;

    // Bits needed to hold a run length in the range 0..run_len.
    function automatic int unsigned run_cnt_width(input int unsigned run_len);
        return $clog2(run_len + 1);
    endfunction

endpackage

// File: rtl/seq_run_detector_sat_counter.sv
// Saturating up-counter with synchronous clear, load-1 and increment enable.
// Priority: rst_i > clr_i > load1_i > inc_i.
module sat_counter #(
    parameter int unsigned        Width = 8,
    parameter logic [Width-1:0]   Limit = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load1_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    // Next count: clear, restart at one, or step up until the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load1_i) begin
            cnt_d = Width'(1);
        end else if (inc_i && (cnt_q != Limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_run_detector.sv
// Moore run detector: flags RUN_LEN identical consecutive accepted samples of w,
// reports the current run polarity/length and counts detection events.
module seq_run_detector
    import seq_run_detector_pkg::*;
#(
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    output logic             z,
    output logic [1:0]       state,
    output logic [3:0]       run_len,
    output logic [CNT_W-1:0] det_count
);

    localparam int unsigned RunW = run_cnt_width(RUN_LEN);
    localparam logic [RunW-1:0] RunMax  = RunW'(RUN_LEN);
    localparam logic [RunW-1:0] RunNear = RunW'(RUN_LEN - 1);

    logic [1:0]      state_q, state_d;
    logic [RunW-1:0] run_len_q;
    logic            run_clr, run_load1, run_inc;
    logic            det_inc;
    logic            cur_bit;

    // Polarity of the run currently being tracked.
    assign cur_bit = (state_q == ST_RUN1);

    // Next-state and run-counter control; w only matters on enabled edges.
    always_comb begin
        state_d   = state_q;
        run_clr   = 1'b0;
        run_load1 = 1'b0;
        run_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d   = w ? ST_RUN1 : ST_RUN0;
                    run_load1 = 1'b1;
                end
            end
            ST_RUN0, ST_RUN1: begin
                if (en) begin
                    if (w == cur_bit) begin
                        run_inc = 1'b1;
                    end else begin
                        // Polarity change: new run starts with this sample.
                        state_d   = w ? ST_RUN1 : ST_RUN0;
                        run_load1 = 1'b1;
                    end
                end
            end
            default: begin
                // Unreachable code: recover regardless of en.
                state_d = ST_IDLE;
                run_clr = 1'b1;
            end
        endcase
    end

    // One detection event per run, on the step into a full run.
    assign det_inc = run_inc && (run_len_q == RunNear);

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .Width (RunW),
        .Limit (RunMax)
    ) u_run_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (run_clr),
        .load1_i (run_load1),
        .inc_i   (run_inc),
        .cnt_o   (run_len_q)
    );

    sat_counter #(
        .Width (CNT_W),
        .Limit ({CNT_W{1'b1}})
    ) u_det_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (1'b0),
        .load1_i (1'b0),
        .inc_i   (det_inc),
        .cnt_o   (det_count)
    );

    // Outputs decode registered state only, so z never follows w directly.
    assign z       = (state_q != ST_IDLE) && (run_len_q == RunMax);
    assign state   = state_q;
    assign run_len = 4'(run_len_q);

endmodule

// File: tb/tb_seq_run_detector.sv
// Directed, table-driven bench for seq_run_detector (RUN_LEN=4, CNT_W=8).
module tb_seq_run_detector;

    logic       clk = 1'b0;
    logic       rst, en, w;
    logic       z;
    logic [1:0] state;
    logic [3:0] run_len;
    logic [7:0] det_count;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       w;
        logic       z;
        logic [1:0] st;
        int         rl;
        int         det;
    } vec_t;

    vec_t vecs[$];

    seq_run_detector #(
        .RUN_LEN (4),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .w         (w),
        .z         (z),
        .state     (state),
        .run_len   (run_len),
        .det_count (det_count)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic e, input logic b, input logic ez,
                       input logic [1:0] est, input int erl, input int edet);
        vec_t v;
        v.rst = r; v.en = e; v.w = b; v.z = ez; v.st = est; v.rl = erl; v.det = edet;
        vecs.push_back(v);
    endtask

    // Drive inputs just after an edge, then sample 1 time unit after the next edge.
    task automatic apply(input logic r, input logic e, input logic b);
        rst = r; en = e; w = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic ez,
                             input logic [1:0] est, input int erl, input int edet);
        check({tag, ".z"}, idx, int'(z), int'(ez));
        check({tag, ".state"}, idx, int'(state), int'(est));
        check({tag, ".run_len"}, idx, int'(run_len), erl);
        check({tag, ".det_count"}, idx, int'(det_count), edet);
    endtask

    initial begin
        int exp_det;
        logic b;

        rst = 1'b1; en = 1'b0; w = 1'b0;

        //   rst en w   z  state  rl det
        // Reset state
        add(1, 0, 0,  0, 2'b00, 0, 0);
        // Six 1s: run_len 1,2,3,4,4,4; z from 4th edge; one detection
        add(0, 1, 1,  0, 2'b10, 1, 0);
        add(0, 1, 1,  0, 2'b10, 2, 0);
        add(0, 1, 1,  0, 2'b10, 3, 0);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        // Reset with en=1 takes priority
        add(1, 1, 1,  0, 2'b00, 0, 0);
        // 0,0,0,1,0,0,0,0: z only after the 8th sample
        add(0, 1, 0,  0, 2'b01, 1, 0);
        add(0, 1, 0,  0, 2'b01, 2, 0);
        add(0, 1, 0,  0, 2'b01, 3, 0);
        add(0, 1, 1,  0, 2'b10, 1, 0);
        add(0, 1, 0,  0, 2'b01, 1, 0);
        add(0, 1, 0,  0, 2'b01, 2, 0);
        add(0, 1, 0,  0, 2'b01, 3, 0);
        add(0, 1, 0,  1, 2'b01, 4, 1);
        // Reset, four 1s, then a 0 drops z; then the 0-run completes
        add(1, 1, 0,  0, 2'b00, 0, 0);
        add(0, 1, 1,  0, 2'b10, 1, 0);
        add(0, 1, 1,  0, 2'b10, 2, 0);
        add(0, 1, 1,  0, 2'b10, 3, 0);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        add(0, 1, 0,  0, 2'b01, 1, 1);
        add(0, 1, 0,  0, 2'b01, 2, 1);
        add(0, 1, 0,  0, 2'b01, 3, 1);
        add(0, 1, 0,  1, 2'b01, 4, 2);
        add(0, 1, 0,  1, 2'b01, 4, 2);
        // Three 1s, then reset mid-run at run_len=3 clears det_count too
        add(0, 1, 1,  0, 2'b10, 1, 2);
        add(0, 1, 1,  0, 2'b10, 2, 2);
        add(0, 1, 1,  0, 2'b10, 3, 2);
        add(1, 1, 1,  0, 2'b00, 0, 0);
        add(0, 1, 1,  0, 2'b10, 1, 0);
        add(0, 1, 1,  0, 2'b10, 2, 0);
        add(0, 1, 1,  0, 2'b10, 3, 0);
        // en=0 holds everything and ignores w
        add(0, 0, 0,  0, 2'b10, 3, 0);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        // Reset, en pattern 1,0,0,1,0,1,1,0 with w=1: only enabled edges count
        add(1, 0, 0,  0, 2'b00, 0, 0);
        add(0, 0, 1,  0, 2'b00, 0, 0);
        add(0, 1, 1,  0, 2'b10, 1, 0);
        add(0, 0, 1,  0, 2'b10, 1, 0);
        add(0, 0, 1,  0, 2'b10, 1, 0);
        add(0, 1, 1,  0, 2'b10, 2, 0);
        add(0, 0, 1,  0, 2'b10, 2, 0);
        add(0, 1, 1,  0, 2'b10, 3, 0);
        add(0, 1, 1,  1, 2'b10, 4, 1);
        add(0, 0, 1,  1, 2'b10, 4, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].en, vecs[i].w);
            check_all("vec", i, vecs[i].z, vecs[i].st, vecs[i].rl, vecs[i].det);
        end

        // 300 alternating 4-bit runs: det_count saturates at 255, z fires every run
        apply(1'b1, 1'b1, 1'b0);
        check_all("sat_reset", 0, 1'b0, 2'b00, 0, 0);
        exp_det = 0;
        for (int r = 0; r < 300; r++) begin
            b = (r % 2) == 1;
            for (int j = 0; j < 3; j++) begin
                apply(1'b0, 1'b1, b);
            end
            check("sat.z_pre", r, int'(z), 0);
            apply(1'b0, 1'b1, b);
            exp_det = (exp_det < 255) ? exp_det + 1 : 255;
            check_all("sat", r, 1'b1, b ? 2'b10 : 2'b01, 4, exp_det);
        end
        // Held saturated count, including further enabled identical samples
        apply(1'b0, 1'b1, b);
        check_all("sat_hold", 0, 1'b1, b ? 2'b10 : 2'b01, 4, 255);
        apply(1'b0, 1'b0, ~b);
        check_all("sat_hold", 1, 1'b1, b ? 2'b10 : 2'b01, 4, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_run_detector.md
Name: seq_run_detector

Overview:
- Moore FSM that consumes the registered serial bit `w` produced by the upstream D flip-flop input stage.
- Asserts `z` while the last RUN_LEN accepted samples are all 0s or all 1s. Overlapping runs are detected.
- Also reports the current run state and keeps a saturating count of detection events.
- Sits directly downstream of the input-register stage and drives LEDs and the display logic.

Parameters:
- RUN_LEN, 4, number of identical consecutive samples that constitutes a detection; legal range 2..15.
- CNT_W, 8, width of the detection-event counter.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  sample enable; `w` is consumed only on edges where en=1.
- w  input  1  registered serial data bit from the upstream flip-flop stage.
- z  output  1  detection flag (Moore; a function of registered state only).
- state  output  2  current FSM state code: IDLE=00, RUN0=01, RUN1=10; 11 is never produced.
- run_len  output  4  current run length, saturating at RUN_LEN; 0 in IDLE.
- det_count  output  CNT_W  number of detection events since reset, saturating at all-ones.

Behaviour:
- Reset, synchronous, priority over en:
  - state=IDLE, run_len=0, z=0, det_count=0.
  - rst applied mid-run clears everything on that edge; the run restarts from IDLE.
- en=0: all registers hold, and `w` is ignored.
- en=1, state IDLE: go to RUN0 if w=0, RUN1 if w=1; run_len=1.
- en=1, state RUNb, w==b: run_len = min(run_len+1, RUN_LEN); state unchanged.
- en=1, state RUNb, w!=b: state = RUN(w), run_len=1. There is no return to IDLE except through reset.
- z = (state!=IDLE) && (run_len==RUN_LEN). It is decoded combinationally from registers only, so it is glitch-free with respect to `w`.
- Latency: z rises on the same edge that accepts the RUN_LEN-th identical sample, with no additional pipeline delay.
- Continued identical samples keep z=1 (overlapping detection) and run_len stays saturated.
- z falls on the edge that accepts a differing sample.
- det_count increments by 1 on each edge where run_len transitions from RUN_LEN-1 to RUN_LEN. One increment per run, not per cycle held.
  - det_count saturates at 2^CNT_W-1 and never wraps.
- Switching polarity, e.g. a long 1-run followed by 0s, requires RUN_LEN new zeros before z reasserts. z is 0 in between.
- run_len is zero-extended to 4 bits.
- Illegal state code 11 is recovered to IDLE with run_len=0 on the next edge, regardless of en.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_RUN0, ST_RUN1;
  - a function computing the run-counter width from RUN_LEN.
- One natural sub-module, sat_counter: a parameterized width/limit saturating incrementer with synchronous clear, load-1 and enable.
  - It is instantiated twice: once for run_len (limit RUN_LEN, load-1 on polarity change) and once for det_count (limit all-ones).
- The FSM next-state logic stays in the top module.

Test Plan (RUN_LEN=4, CNT_W=8):
- Reset then w=1 for 6 en cycles -> run_len 1,2,3,4,4,4; z=1 from the 4th accepting edge; det_count=1; state=10.
- After reset: w=0,0,0,1,0,0,0,0 -> z stays 0 through sample 7, rises after sample 8; det_count=1; run_len reset to 1 on the `1` sample.
- Run of four 1s, then w=0 -> z drops on that edge, state=01, run_len=1; four more 0s -> z=1, det_count=2.
- en toggled 1,0,0,1,… with w=1 held -> only enabled edges advance run_len; z rises after the 4th enabled edge, not the 4th clock.
- rst asserted for one edge during run_len=3 with en=1 -> next state IDLE, run_len=0, z=0, det_count=0; the following three 1s do not assert z.
- Force 300 alternating runs of four identical bits (0000 1111 …) -> det_count saturates at 255 and holds; z still asserts on every run.
